floor_request_queue: RTL

Upstream stage of the 8-floor lift controller. Conditions raw call-button inputs (2-flop sync plus debounce), latches each press as a pending request, and offers pending floors one at a time to the controller over a valid/ready handshake. A floor stays tracked until the controller reports it served, so the lamp output reflects the true outstanding set.

---
 rtl/lift_pkg.sv | 37 +++
 rtl/button_debounce.sv | 56 +++++
 rtl/floor_request_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// ---------------------------------------------------------------------------
// lift_pkg
// Shared definitions for the 8-floor lift controller and its request queue.
//   FLOORS   : number of floors served
//   FLOOR_W  : width of a floor index (reused by the controller)
//   state_e  : request-queue FSM states
//   rr_pick  : round-robin scan helper used by the queue's grant logic
// ---------------------------------------------------------------------------
package lift_pkg;

    localparam int FLOORS  = 8;
    localparam int FLOOR_W = 3;

    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [FLOORS-1:0]  floor_mask_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // First set bit of req scanning upward from (ptr+1), wrapping. The loop
    // runs from the lowest priority position down to the highest, so the
    // last hit assigned is the winner. The index wraps naturally at FLOOR_W
    // bits, and the offset FLOORS folds to ptr itself (lowest priority).
    function automatic floor_t rr_pick(input floor_mask_t req, input floor_t ptr);
        floor_t pick;
        floor_t idx;
        pick = '0;
        for (int i = FLOORS; i >= 1; i--) begin
            idx = ptr + floor_t'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions one raw call button: 2-flop synchronizer, saturating stable-high
// counter, and a registered one-cycle press pulse emitted once per hold.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   button_i : raw asynchronous button level, active high
//   press_o  : one-cycle pulse when the button has been high for
//              DEBOUNCE_CYCLES consecutive synchronized samples
// DEBOUNCE_CYCLES is valid in 1..255.
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic press_o
);

    localparam logic [7:0] CNT_MAX  = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] cnt_q;
    logic       press_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;

            // The counter parks at CNT_MAX while held, so the pulse can only
            // fire again after a low sample has cleared it.
            if (!sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 8'd1;
            end

            // Pulse on the same edge the counter reaches CNT_MAX.
            press_q <= sync2_q && (cnt_q == CNT_LAST);
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/floor_request_queue.sv
// ---------------------------------------------------------------------------
// floor_request_queue
// Upstream stage of the lift controller. Debounces the call buttons, keeps
// the pending (requested, not yet offered) and issued (offered, not yet
// served) sets, and offers pending floors round-robin over valid/ready.
//   clk            : system clock
//   reset          : asynchronous active-low reset
//   buttons        : raw call buttons, bit n = floor n
//   emergency_stop : blocks new offers (never retracts an active one)
//   req_ready      : controller accepts the offered request this cycle
//   served_valid   : one-cycle pulse, controller served served_floor
//   served_floor   : floor just served
//   req_valid      : req_floor holds an offered request
//   req_floor      : offered floor
//   pending        : floors requested but not yet offered
//   lamps          : pending | issued, every floor not yet served
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module floor_request_queue
    import lift_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  buttons,
    input  logic               emergency_stop,
    input  logic               req_ready,
    input  logic               served_valid,
    input  logic [FLOOR_W-1:0] served_floor,
    output logic               req_valid,
    output logic [FLOOR_W-1:0] req_floor,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOORS-1:0]  lamps
);

    floor_mask_t press;

    for (genvar g = 0; g < FLOORS; g++) begin : g_db
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .button_i (buttons[g]),
            .press_o  (press[g])
        );
    end

    state_e      state_q;
    floor_t      ptr_q;
    logic        req_valid_q;
    floor_t      req_floor_q;
    floor_mask_t pending_q, pending_d;
    floor_mask_t issued_q,  issued_d;
    floor_mask_t lamps_q;
    logic        handshake;

    assign handshake = req_valid_q && req_ready;

    // Update order matters: press first, then handshake, then serve, so a
    // serve always wins over a same-cycle press or handshake on its floor.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pending_d = pending_q | (press & ~issued_q);
        issued_d  = issued_q;
        if (handshake) begin
            pending_d[req_floor_q] = 1'b0;
            issued_d[req_floor_q]  = 1'b1;
        end
        if (served_valid) begin
            pending_d[served_floor] = 1'b0;
            issued_d[served_floor]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            issued_q  <= '0;
            lamps_q   <= '0;
        end else begin
            pending_q <= pending_d;
            issued_q  <= issued_d;
            lamps_q   <= pending_d | issued_d;
        end
    end

    // Offer FSM. The grant is computed from registered pending, so a request
    // set at edge e is offered at edge e+1. ptr starts at the top floor so
    // the first scan after reset begins at floor 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= floor_t'(FLOORS - 1);
            req_valid_q <= 1'b0;
            req_floor_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((|pending_q) && !emergency_stop) begin
                        req_floor_q <= rr_pick(pending_q, ptr_q);
                        req_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    // Held until accepted; emergency_stop is not consulted.
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        ptr_q       <= req_floor_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_floor = req_floor_q;
    assign pending   = pending_q;
    assign lamps     = lamps_q;

endmodule
